memory_access_unit: RTL and testbench
=====================================

Name: memory_access_unit

Overview:
Core-side initiator for the external memory interface: accepts one load/store request at a time from the execute stage and drives the memory port (enable, is_write, op_size, addr, write data).
- Probes access_fault with enable low before any access, so a faulting store never commits.
- Masks and sign-extends load data, checks alignment.
- Returns a single-cycle response pulse with data or fault status to the trap logic.

Parameters:
none (address and data fixed at 32 bits; op_size encoding 0=byte, 1=half, 2=word, 3=illegal)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit idle, request accepted when req_valid & req_ready
req_is_write  input  1  1=store, 0=load
req_op_size  input  2  access size
req_sign_extend  input  1  sign-extend byte/half loads; ignored for word and stores
req_addr  input  32  byte address
req_data  input  32  store data, low bytes used
resp_valid  output  1  one-cycle response pulse
resp_data  output  32  load result (0 for stores and faults)
resp_fault  output  1  access fault or illegal size
resp_misaligned  output  1  misaligned address
resp_fault_addr  output  32  faulting byte address (valid with resp_fault or resp_misaligned)
mem_enable  output  1  memory access strobe
mem_is_write  output  1  to memory
mem_op_size  output  2  to memory
mem_addr  output  32  to memory
mem_wdata  output  32  to memory write input
mem_rdata  input  32  combinational read result from memory
mem_access_fault  input  1  combinational fault for current mem_addr/mem_is_write

Behaviour:
- Reset (async): state IDLE; all outputs 0; req_ready forced 0 while reset is high. Mid-operation reset aborts with no response and no further mem_enable.
- States: IDLE, PROBE, ACCESS, DONE. req_ready = (state==IDLE) & ~reset.
- IDLE, on accept, latch all request fields, then:
  - Size 3: go to DONE with resp_fault=1, resp_fault_addr=req_addr.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): go to DONE with resp_misaligned=1, resp_fault_addr=req_addr.
  - Otherwise: go to PROBE.
- PROBE: drive mem_addr, mem_is_write, mem_op_size and mem_wdata from the latched fields; mem_enable=0.
  - mem_access_fault=1: go to DONE with resp_fault=1, resp_fault_addr=mem_addr.
  - Else: go to ACCESS.
- ACCESS: same drives with mem_enable=1 for exactly one cycle.
  - Capture mem_rdata masked to size (byte [7:0], half [15:0]), then zero- or sign-extended per req_sign_extend.
  - Store: captured data discarded, resp_data=0.
  - Go to DONE.
- DONE: resp_valid=1 for one cycle with registered resp_* values, then IDLE. resp_* return to 0 the following cycle.
- No response backpressure. A new request can be accepted the cycle after DONE.
- Latency from accept edge to resp_valid:
  - aligned: 3 cycles
  - probe fault: 2 cycles
  - misaligned/illegal: 1 cycle
- mem_enable is never high outside ACCESS. mem_* outputs are 0 in IDLE and DONE.

Optional Feature:
MISALIGNED_SPLIT_EN
- Defined: misaligned half/word accesses are split into N byte accesses (N=2 or 4) at addresses addr+i, i=0..N-1, in ascending order.
  - Address wraps mod 2^32 (0xFFFFFFFF+1 = 0x00000000).
  - Each byte runs PROBE then ACCESS with mem_op_size=0 and mem_wdata[7:0]=req_data[8i+7:8i]; load bytes are assembled into result[8i+7:8i] before extension.
  - A fault on byte i aborts: resp_fault=1, resp_fault_addr=addr+i. Store bytes 0..i-1 remain written. resp_misaligned is never set.
  - Latency is 2N+1 cycles.
- Undefined: misaligned requests return resp_misaligned as described above, and no split-counter logic is present.

Test Plan:
1. Load word, addr 0x100, memory 0xDEADBEEF, no fault -> mem_enable high exactly one cycle; resp_valid 3 cycles after accept; resp_data=0xDEADBEEF, resp_fault=0.
2. Load byte, addr 0x103, mem_rdata[7:0]=0x80: with sign_extend=1 -> resp_data=0xFFFFFF80; with sign_extend=0 -> resp_data=0x00000080.
3. Store word to 0x200 with mem_access_fault=1 -> mem_enable never asserted; resp_fault=1, resp_fault_addr=0x200, resp_valid 2 cycles after accept.
4. Load half at 0x101, macro undefined -> resp_misaligned=1, resp_fault_addr=0x101, 1-cycle latency, no mem_* activity.
5. MISALIGNED_SPLIT_EN: store word 0x11223344 at 0xFFFFFFFE, fault only at 0x00000000 -> bytes 0x44@0xFFFFFFFE and 0x33@0xFFFFFFFF written; resp_fault=1, resp_fault_addr=0x00000000.
6. Assert reset during ACCESS of a load -> mem_enable drops immediately, no resp_valid; after release req_ready=1 and the next request completes normally.

Source files
------------

// File: rtl/memory_access_unit.sv
// memory_access_unit: core-side initiator for the external memory port.
// Accepts one load/store at a time, probes mem_access_fault with
// mem_enable low, then performs a single enabled access. Load data is
// masked to size and zero/sign-extended. Every request ends with a
// one-cycle response pulse that carries the data or the fault status.
//
// Optional build macro: MISALIGNED_SPLIT_EN. When it is defined, a
// misaligned half/word access is split into ascending byte accesses
// instead of being rejected.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   req_valid/req_ready     request handshake (ready only when idle)
//   req_is_write, req_op_size, req_sign_extend, req_addr, req_data
//                           request fields (size: 0=byte 1=half 2=word 3=illegal)
//   resp_valid              one-cycle response pulse
//   resp_data, resp_fault, resp_misaligned, resp_fault_addr
//                           response fields, zero outside the pulse
//   mem_enable, mem_is_write, mem_op_size, mem_addr, mem_wdata
//                           memory port drives
//   mem_rdata, mem_access_fault
//                           combinational memory read data / fault
module memory_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_write,
  input  logic [1:0]  req_op_size,
  input  logic        req_sign_extend,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_fault,
  output logic        resp_misaligned,
  output logic [31:0] resp_fault_addr,
  output logic        mem_enable,
  output logic        mem_is_write,
  output logic [1:0]  mem_op_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_access_fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  logic        is_write_q;
  logic [1:0]  op_size_q;
  logic        sign_extend_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic [31:0] resp_data_q;
  logic        resp_fault_q;
  logic        resp_misaligned_q;
  logic [31:0] resp_fault_addr_q;

  logic        accept;
  logic        size_illegal;
  logic        addr_misaligned;
  logic        reject_misaligned;
  logic        last_access;
  logic        in_mem;
  logic [31:0] access_addr;
  logic [31:0] access_wdata;
  logic [1:0]  access_size;
  logic [31:0] load_word;

  function automatic logic [31:0] extend(input logic [1:0] size,
                                         input logic sext,
                                         input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'd0:    r = sext ? {{24{d[7]}}, d[7:0]}   : {24'd0, d[7:0]};
      2'd1:    r = sext ? {{16{d[15]}}, d[15:0]} : {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign accept          = req_valid & req_ready;
  assign size_illegal    = (req_op_size == 2'd3);
  assign addr_misaligned = ((req_op_size == 2'd1) & req_addr[0]) |
                           ((req_op_size == 2'd2) & (req_addr[1:0] != 2'd0));

`ifdef MISALIGNED_SPLIT_EN
  logic        split_q;
  logic [1:0]  idx_q;
  logic [1:0]  last_idx_q;
  logic [31:0] assembled_q;

  assign reject_misaligned = 1'b0;

  // idx_q stays 0 for unsplit accesses, so the address adder serves both.
  always_comb begin
    access_addr  = addr_q + {30'd0, idx_q};
    access_size  = op_size_q;
    access_wdata = data_q;
    load_word    = mem_rdata;
    last_access  = 1'b1;
    if (split_q) begin
      access_size  = 2'd0;
      access_wdata = {24'd0, data_q[{idx_q, 3'b000} +: 8]};
      load_word    = assembled_q;
      load_word[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
      last_access  = (idx_q == last_idx_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      split_q     <= 1'b0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      assembled_q <= '0;
    end else if (accept) begin
      split_q     <= addr_misaligned & ~size_illegal;
      idx_q       <= '0;
      last_idx_q  <= (req_op_size == 2'd1) ? 2'd1 : 2'd3;
      assembled_q <= '0;
    end else if (state == ACCESS) begin
      assembled_q <= load_word;
      if (!last_access) idx_q <= idx_q + 2'd1;
    end
  end
`else
  assign reject_misaligned = addr_misaligned;
  assign access_addr       = addr_q;
  assign access_size       = op_size_q;
  assign access_wdata      = data_q;
  assign load_word         = mem_rdata;
  assign last_access       = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (size_illegal || reject_misaligned) state_next = DONE;
          else                                   state_next = PROBE;
        end
      end
      PROBE:   state_next = mem_access_fault ? DONE : ACCESS;
      ACCESS:  state_next = last_access ? DONE : PROBE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_write_q        <= 1'b0;
      op_size_q         <= '0;
      sign_extend_q     <= 1'b0;
      addr_q            <= '0;
      data_q            <= '0;
      resp_data_q       <= '0;
      resp_fault_q      <= 1'b0;
      resp_misaligned_q <= 1'b0;
      resp_fault_addr_q <= '0;
    end else begin
      if (accept) begin
        is_write_q        <= req_is_write;
        op_size_q         <= req_op_size;
        sign_extend_q     <= req_sign_extend;
        addr_q            <= req_addr;
        data_q            <= req_data;
        resp_data_q       <= '0;
        resp_fault_q      <= size_illegal;
        resp_misaligned_q <= ~size_illegal & reject_misaligned;
        resp_fault_addr_q <= (size_illegal | reject_misaligned) ? req_addr : '0;
      end else if (state == PROBE) begin
        if (mem_access_fault) begin
          resp_fault_q      <= 1'b1;
          resp_fault_addr_q <= access_addr;
        end
      end else if (state == ACCESS) begin
        resp_data_q <= is_write_q ? '0 : extend(op_size_q, sign_extend_q, load_word);
      end
    end
  end

  assign in_mem          = (state == PROBE) || (state == ACCESS);
  assign req_ready       = (state == IDLE) & ~reset;
  assign mem_enable      = (state == ACCESS);
  assign mem_is_write    = in_mem & is_write_q;
  assign mem_op_size     = in_mem ? access_size  : '0;
  assign mem_addr        = in_mem ? access_addr  : '0;
  assign mem_wdata       = in_mem ? access_wdata : '0;

  assign resp_valid      = (state == DONE);
  assign resp_data       = resp_valid ? resp_data_q       : '0;
  assign resp_fault      = resp_valid & resp_fault_q;
  assign resp_misaligned = resp_valid & resp_misaligned_q;
  assign resp_fault_addr = resp_valid ? resp_fault_addr_q : '0;

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: table of directed load/store
// vectors plus hand-written sequences for reset and (when built with
// MISALIGNED_SPLIT_EN) the split-store fault case.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_write, req_sign_extend;
  logic [1:0]  req_op_size;
  logic [31:0] req_addr, req_data;
  logic        resp_valid, resp_fault, resp_misaligned;
  logic [31:0] resp_data, resp_fault_addr;
  logic        mem_enable, mem_is_write, mem_access_fault;
  logic [1:0]  mem_op_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] rdata_val;
  logic        fault_en;
  logic [31:0] fault_at;

  int checks = 0;
  int errors = 0;
  int en_count = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [1:0]  wr_size[$];

  memory_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_write(req_is_write), .req_op_size(req_op_size),
    .req_sign_extend(req_sign_extend), .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
    .resp_misaligned(resp_misaligned), .resp_fault_addr(resp_fault_addr),
    .mem_enable(mem_enable), .mem_is_write(mem_is_write), .mem_op_size(mem_op_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_access_fault(mem_access_fault)
  );

  always #5 clk = ~clk;

  // Memory model: constant read data, fault at one selected address.
  assign mem_rdata        = rdata_val;
  assign mem_access_fault = fault_en & (mem_addr == fault_at);

  always @(posedge clk) begin
    if (mem_enable === 1'b1) begin
      en_count = en_count + 1;
      if (mem_is_write === 1'b1) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
        wr_size.push_back(mem_op_size);
      end
    end
  end

  typedef struct packed {
    logic        w;
    logic [1:0]  size;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        flt;
    logic [31:0] flt_addr;
    int          lat;
    logic [31:0] data;
    logic        fault;
    logic        mis;
    logic [31:0] faddr;
    int          en;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present a request at a negedge, release it after the accept edge, and
  // return the number of cycles until resp_valid (0 if the bound expires).
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_is_write = w; req_op_size = sz;
    req_sign_extend = sx; req_addr = a; req_data = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_vec(input int i);
    int lat, en0, wr0;
    rdata_val = vecs[i].rdata;
    fault_en  = vecs[i].flt;
    fault_at  = vecs[i].flt_addr;
    en0 = en_count;
    wr0 = wr_addr.size();
    do_req(vecs[i].w, vecs[i].size, vecs[i].sx, vecs[i].addr, vecs[i].wdata, lat);
    chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
    chk($sformatf("v%0d_data", i), resp_data, vecs[i].data);
    chk($sformatf("v%0d_fault", i), {31'd0, resp_fault}, {31'd0, vecs[i].fault});
    chk($sformatf("v%0d_misaligned", i), {31'd0, resp_misaligned}, {31'd0, vecs[i].mis});
    chk($sformatf("v%0d_fault_addr", i), resp_fault_addr, vecs[i].faddr);
    chk($sformatf("v%0d_mem_en_cycles", i), en_count - en0, vecs[i].en);
    if (vecs[i].w && vecs[i].en == 1) begin
      chk($sformatf("v%0d_write_count", i), wr_addr.size() - wr0, 1);
      if (wr_addr.size() > wr0) begin
        chk($sformatf("v%0d_write_addr", i), wr_addr[wr0], vecs[i].addr);
        chk($sformatf("v%0d_write_data", i), wr_data[wr0], vecs[i].wdata);
        chk($sformatf("v%0d_write_size", i), {30'd0, wr_size[wr0]}, {30'd0, vecs[i].size});
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d_pulse_end", i), {31'd0, resp_valid}, 32'd0);
    chk($sformatf("v%0d_data_cleared", i), resp_data, 32'd0);
    chk($sformatf("v%0d_ready_again", i), {31'd0, req_ready}, 32'd1);
    chk($sformatf("v%0d_idle_addr", i), mem_addr, 32'd0);
  endtask

  initial begin
    int lat, wr0, en0;
    logic saw;
    //            w  sz sx addr          wdata         rdata         flt faddr    lat data          flt mis faddr        en
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0,   3, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,   1};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h12345680, 1'b0, 32'h0,   3, 32'hFFFFFF80, 1'b0, 1'b0, 32'h0,   1};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h12345680, 1'b0, 32'h0,   3, 32'h00000080, 1'b0, 1'b0, 32'h0,   1};
    vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, 32'h0,        1'b1, 32'h200, 2, 32'h0,        1'b1, 1'b0, 32'h200, 0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h101, 32'h0,        32'h0,        1'b0, 32'h0,   1, 32'h0,        1'b0, 1'b1, 32'h101, 0};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'h00008001, 1'b0, 32'h0,   3, 32'hFFFF8001, 1'b0, 1'b0, 32'h0,   1};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'hFFFF7FFF, 1'b0, 32'h0,   3, 32'h00007FFF, 1'b0, 1'b0, 32'h0,   1};
    vecs[7]  = '{1'b0, 2'd3, 1'b0, 32'h300, 32'h0,        32'h0,        1'b0, 32'h0,   1, 32'h0,        1'b1, 1'b0, 32'h300, 0};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h401, 32'hAABBCCDD, 32'h55555555, 1'b0, 32'h0,   3, 32'h0,        1'b0, 1'b0, 32'h0,   1};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0,        32'h0,        1'b0, 32'h0,   1, 32'h0,        1'b0, 1'b1, 32'h102, 0};
    vecs[10] = '{1'b0, 2'd2, 1'b1, 32'h104, 32'h0,        32'h80000000, 1'b0, 32'h0,   3, 32'h80000000, 1'b0, 1'b0, 32'h0,   1};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h500, 32'h0,        32'hFFFFFFFF, 1'b1, 32'h500, 2, 32'h0,        1'b1, 1'b0, 32'h500, 0};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h2FE, 32'h0000BEEF, 32'h0,        1'b0, 32'h0,   3, 32'h0,        1'b0, 1'b0, 32'h0,   1};

    req_valid = 1'b0; req_is_write = 1'b0; req_op_size = 2'd0;
    req_sign_extend = 1'b0; req_addr = '0; req_data = '0;
    rdata_val = '0; fault_en = 1'b0; fault_at = '0;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_mem_enable", {31'd0, mem_enable}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
`ifdef MISALIGNED_SPLIT_EN
      if (vecs[i].mis) continue;
`endif
      run_vec(i);
    end

    // Reset asserted while the access cycle of a load is in progress.
    rdata_val = 32'h01020304; fault_en = 1'b0;
    en0 = en_count;
    @(negedge clk);
    req_valid = 1'b1; req_is_write = 1'b0; req_op_size = 2'd2;
    req_sign_extend = 1'b0; req_addr = 32'h600; req_data = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_enable_high", {31'd0, mem_enable}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_enable_drop", {31'd0, mem_enable}, 32'd0);
    chk("rst_mid_ready_low", {31'd0, req_ready}, 32'd0);
    chk("rst_mid_no_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid === 1'b1 || mem_enable === 1'b1) saw = 1'b1;
    end
    chk("rst_mid_quiet_after", {31'd0, saw}, 32'd0);
    chk("rst_mid_enable_cycles", en_count - en0, 0);
    chk("rst_mid_ready_after", {31'd0, req_ready}, 32'd1);
    run_vec(0);

`ifdef MISALIGNED_SPLIT_EN
    // Split store wrapping past the top of the address space; byte 2 faults.
    fault_en = 1'b1; fault_at = 32'h0;
    wr0 = wr_addr.size();
    do_req(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h11223344, lat);
    chk("split_latency", lat, 6);
    chk("split_fault", {31'd0, resp_fault}, 32'd1);
    chk("split_misaligned", {31'd0, resp_misaligned}, 32'd0);
    chk("split_fault_addr", resp_fault_addr, 32'h0);
    chk("split_write_count", wr_addr.size() - wr0, 2);
    if (wr_addr.size() >= wr0 + 2) begin
      chk("split_wr0_addr", wr_addr[wr0], 32'hFFFFFFFE);
      chk("split_wr0_data", {24'd0, wr_data[wr0][7:0]}, 32'h44);
      chk("split_wr1_addr", wr_addr[wr0+1], 32'hFFFFFFFF);
      chk("split_wr1_data", {24'd0, wr_data[wr0+1][7:0]}, 32'h33);
      chk("split_wr_size", {30'd0, wr_size[wr0+1]}, 32'd0);
    end
    fault_en = 1'b0;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
